demux_scan_sequencer: RTL and testbench

DEMUX_SCAN_SEQUENCER -- requirements
Module: demux_scan_sequencer

---
 rtl/demux_pkg.sv | 14 +
 rtl/demux_scan_sequencer.sv | 141 ++++++++++++++
 tb/tb_demux_scan_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the demux channel sequencers: FSM state encoding and default geometry.
package demux_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } demux_state_e;

   localparam int unsigned NUM_CH_DEF = 16;
   localparam int unsigned SEL_W_DEF  = 4;
   localparam int unsigned HOLD_W     = 8;

endpackage

// File: rtl/demux_scan_sequencer.sv
// Walks a captured frame across NUM_CH demux channels, holding each slot HOLD_CYCLES clocks,
// then pulses done for one cycle; abort or reset drops the frame silently.
module demux_scan_sequencer
   import demux_pkg::*;
#(
   parameter int unsigned NUM_CH      = NUM_CH_DEF,
   parameter int unsigned SEL_W       = SEL_W_DEF,
   parameter int unsigned HOLD_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [NUM_CH-1:0] s_data,
   input  logic [NUM_CH-1:0] s_mask,
   input  logic              abort,
   output logic [SEL_W-1:0]  sel,
   output logic              dout,
   output logic              dout_valid,
   output logic              busy,
   output logic              done
);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [SEL_W-1:0]  CH_LAST   = SEL_W'(NUM_CH - 1);

   demux_state_e      state_q, state_d;
   logic [SEL_W-1:0]  chan_q, chan_d, chan_nxt;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [NUM_CH-1:0] data_q, data_d;
   logic [NUM_CH-1:0] mask_q, mask_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic              dout_q, dout_d;
   logic              dv_q, dv_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   // Only the handshake decode is combinational; abort and reset both veto acceptance.
   assign s_ready = (state_q == IDLE) & ~abort & ~rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         chan_q  <= '0;
         hold_q  <= '0;
         data_q  <= '0;
         mask_q  <= '0;
         sel_q   <= '0;
         dout_q  <= 1'b0;
         dv_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         chan_q  <= chan_d;
         hold_q  <= hold_d;
         data_q  <= data_d;
         mask_q  <= mask_d;
         sel_q   <= sel_d;
         dout_q  <= dout_d;
         dv_q    <= dv_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      chan_d   = chan_q;
      hold_d   = hold_q;
      data_d   = data_q;
      mask_d   = mask_q;
      sel_d    = sel_q;
      dout_d   = dout_q;
      dv_d     = dv_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      chan_nxt = chan_q + SEL_W'(1);

      case (state_q)
         IDLE: begin
            if (s_valid && s_ready) begin
               state_d = SCAN;
               data_d  = s_data;
               mask_d  = s_mask;
               chan_d  = '0;
               hold_d  = HOLD_LAST;
               sel_d   = '0;
               dout_d  = s_data[0] & s_mask[0];
               dv_d    = s_mask[0];
               busy_d  = 1'b1;
            end
         end
         SCAN: begin
            if (abort) begin
               state_d = IDLE;
               sel_d   = '0;
               dout_d  = 1'b0;
               dv_d    = 1'b0;
               busy_d  = 1'b0;
            end else if (hold_q != '0) begin
               hold_d = hold_q - HOLD_W'(1);
            end else if (chan_q == CH_LAST) begin
               state_d = DONE;
               sel_d   = '0;
               dout_d  = 1'b0;
               dv_d    = 1'b0;
               done_d  = 1'b1;
            end else begin
               // Slot boundary: advance channel and present its bit on the same edge.
               chan_d = chan_nxt;
               hold_d = HOLD_LAST;
               sel_d  = chan_nxt;
               dout_d = data_q[chan_nxt] & mask_q[chan_nxt];
               dv_d   = mask_q[chan_nxt];
            end
         end
         DONE: begin
            state_d = IDLE;
            sel_d   = '0;
            dout_d  = 1'b0;
            dv_d    = 1'b0;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            sel_d   = '0;
            dout_d  = 1'b0;
            dv_d    = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign sel        = sel_q;
   assign dout       = dout_q;
   assign dout_valid = dv_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_demux_scan_sequencer.sv
// Directed scoreboard bench: per-cycle expected outputs are queued when a frame is offered and
// popped one per clock against the selected instance (HOLD_CYCLES=1 or HOLD_CYCLES=3).
module tb_demux_scan_sequencer;

   typedef struct packed {
      logic [3:0] sel;
      logic       dout;
      logic       dv;
      logic       busy;
      logic       done;
   } out_t;

   logic        clk;
   logic        rst;
   logic        s_valid_a, s_valid_b;
   logic        s_ready_a, s_ready_b;
   logic [15:0] s_data, s_mask;
   logic        abort;
   logic [3:0]  sel_a, sel_b;
   logic        dout_a, dout_b, dv_a, dv_b, busy_a, busy_b, done_a, done_b;
   out_t        obs_a, obs_b;

   out_t        exp_q[$];
   int          n_checks;
   int          n_errors;
   int          cyc;
   logic        use_b;

   demux_scan_sequencer #(.NUM_CH(16), .SEL_W(4), .HOLD_CYCLES(1)) u_h1 (
      .clk(clk), .rst(rst), .s_valid(s_valid_a), .s_ready(s_ready_a),
      .s_data(s_data), .s_mask(s_mask), .abort(abort),
      .sel(sel_a), .dout(dout_a), .dout_valid(dv_a), .busy(busy_a), .done(done_a)
   );

   demux_scan_sequencer #(.NUM_CH(16), .SEL_W(4), .HOLD_CYCLES(3)) u_h3 (
      .clk(clk), .rst(rst), .s_valid(s_valid_b), .s_ready(s_ready_b),
      .s_data(s_data), .s_mask(s_mask), .abort(abort),
      .sel(sel_b), .dout(dout_b), .dout_valid(dv_b), .busy(busy_b), .done(done_b)
   );

   assign obs_a = {sel_a, dout_a, dv_a, busy_a, done_a};
   assign obs_b = {sel_b, dout_b, dv_b, busy_b, done_b};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      n_checks++;
      assert (obs === exp_v)
      else begin
         n_errors++;
         $error("FAIL %s: got %h want %h", tag, obs, exp_v);
      end
   endtask

   function automatic void push_slot(input logic [15:0] d, input logic [15:0] m, input int k);
      out_t e;
      e.sel  = 4'(k);
      e.dout = d[k] & m[k];
      e.dv   = m[k];
      e.busy = 1'b1;
      e.done = 1'b0;
      exp_q.push_back(e);
   endfunction

   function automatic void push_idle(input int n);
      out_t e;
      e = '0;
      for (int i = 0; i < n; i++) exp_q.push_back(e);
   endfunction

   function automatic void push_frame(input logic [15:0] d, input logic [15:0] m, input int h);
      out_t e;
      for (int k = 0; k < 16; k++)
         for (int r = 0; r < h; r++) push_slot(d, m, k);
      e      = '0;
      e.busy = 1'b1;
      e.done = 1'b1;
      exp_q.push_back(e);
   endfunction

   function automatic logic [15:0] data_at(input int c);
      return 16'(c * 16'h1357) ^ 16'h9AC5;
   endfunction

   // One clock: sample 2ns after the edge and compare against the next queued expectation.
   task automatic cycle();
      out_t o, e;
      @(posedge clk);
      #2;
      cyc++;
      o = use_b ? obs_b : obs_a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk($sformatf("cyc%0d%s", cyc, use_b ? "_h3" : "_h1"), o, e);
      end
   endtask

   task automatic drain();
      while (exp_q.size() > 0) cycle();
   endtask

   task automatic offer_a(input logic [15:0] d, input logic [15:0] m);
      s_data    = d;
      s_mask    = m;
      s_valid_a = 1'b1;
      cycle();
      s_valid_a = 1'b0;
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      cyc       = 0;
      use_b     = 1'b0;
      rst       = 1'b1;
      s_valid_a = 1'b0;
      s_valid_b = 1'b0;
      s_data    = '0;
      s_mask    = '0;
      abort     = 1'b0;

      repeat (2) @(posedge clk);
      #2;
      s_valid_a = 1'b1;
      #1;
      chk("rst_out_h1", obs_a, 8'h00);
      chk("rst_out_h3", obs_b, 8'h00);
      chk("rst_srdy", 8'(s_ready_a), 8'h00);
      s_valid_a = 1'b0;
      rst = 1'b0;

      // Full frame, handshake on the first edge after reset release.
      s_data    = 16'hA5C3;
      s_mask    = 16'hFFFF;
      s_valid_a = 1'b1;
      #1 chk("t1_srdy_c0", 8'(s_ready_a), 8'h01);
      push_frame(16'hA5C3, 16'hFFFF, 1);
      push_idle(1);
      cycle();
      s_valid_a = 1'b0;
      chk("t1_srdy_busy", 8'(s_ready_a), 8'h00);
      drain();
      chk("t1_srdy_c18", 8'(s_ready_a), 8'h01);

      // Masked slots keep their duration.
      push_frame(16'hFFFF, 16'h00F0, 1);
      push_idle(1);
      offer_a(16'hFFFF, 16'h00F0);
      drain();

      // All-zero mask still runs the full frame.
      push_frame(16'hFFFF, 16'h0000, 1);
      push_idle(1);
      offer_a(16'hFFFF, 16'h0000);
      drain();

      // Abort together with s_valid in IDLE accepts nothing.
      abort     = 1'b1;
      s_valid_a = 1'b1;
      #1 chk("idle_abort_srdy", 8'(s_ready_a), 8'h00);
      push_idle(2);
      cycle();
      abort     = 1'b0;
      s_valid_a = 1'b0;
      cycle();

      // Abort in cycle 6 of a frame, then a normal frame.
      for (int k = 0; k < 6; k++) push_slot(16'hA5C3, 16'hFFFF, k);
      push_idle(2);
      offer_a(16'hA5C3, 16'hFFFF);
      repeat (5) cycle();
      abort = 1'b1;
      cycle();
      abort = 1'b0;
      cycle();
      push_frame(16'h3C5A, 16'hFFFF, 1);
      push_idle(1);
      offer_a(16'h3C5A, 16'hFFFF);
      drain();

      // Three-cycle hold on the second instance.
      use_b = 1'b1;
      push_frame(16'h5AA5, 16'hFFFF, 3);
      push_idle(1);
      s_data    = 16'h5AA5;
      s_mask    = 16'hFFFF;
      s_valid_b = 1'b1;
      cycle();
      s_valid_b = 1'b0;
      drain();
      chk("t3_srdy_h3", 8'(s_ready_b), 8'h01);
      use_b = 1'b0;

      // s_valid held high with changing data: one frame per IDLE visit, then reset mid-frame.
      s_mask = 16'hFFFF;
      push_frame(data_at(0), 16'hFFFF, 1);
      push_idle(1);
      push_frame(data_at(18), 16'hFFFF, 1);
      push_idle(1);
      for (int k = 0; k < 9; k++) push_slot(data_at(36), 16'hFFFF, k);
      for (int c = 0; c <= 44; c++) begin
         s_data    = data_at(c);
         s_valid_a = 1'b1;
         cycle();
      end
      rst = 1'b1;
      #1;
      chk("rst_mid_out", obs_a, 8'h00);
      chk("rst_mid_srdy", 8'(s_ready_a), 8'h00);
      @(posedge clk);
      #2;
      chk("rst_hold_out", obs_a, 8'h00);
      rst       = 1'b0;
      s_valid_a = 1'b0;
      push_idle(3);
      drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
